// File: rtl/ddr_init_seq_if.sv
// ddr_init_seq_if: start request, status and DRAM command pins between the init sequencer and the pad mux.
interface ddr_init_seq_if #(
  parameter int ROW_W = 13,
  parameter int BA_W  = 2
);
  logic             initddr;
  logic             cke;
  logic             csbar;
  logic             rasbar;
  logic             casbar;
  logic             webar;
  logic [BA_W-1:0]  ba;
  logic [ROW_W-1:0] a;
  logic             odt;
  logic             ready;
  logic             busy;
  logic [3:0]       step;
  modport master (
    input  initddr,
    output cke, csbar, rasbar, casbar, webar, ba, a, odt, ready, busy, step
  );
  modport slave (
    output initddr,
    input  cke, csbar, rasbar, casbar, webar, ba, a, odt, ready, busy, step
  );
endinterface

// File: rtl/ddr_init_seq.sv
// ddr_init_seq: DDR2/DDR3 power-up init sequencer driving registered DRAM command pins until ready.
module ddr_init_seq #(
  parameter int               DDR3    = 0,
  parameter int               ROW_W   = 13,
  parameter int               BA_W    = 2,
  parameter int               CNT_W   = 16,
  parameter int               T_CKE   = 200,
  parameter int               T_XPR   = 200,
  parameter int               T_RP    = 4,
  parameter int               T_MRD   = 4,
  parameter int               T_RFC   = 64,
  parameter int               T_FINAL = 200,
  parameter logic [ROW_W-1:0] MR0     = '0,
  parameter logic [ROW_W-1:0] EMR1    = '0,
  parameter logic [ROW_W-1:0] EMR2    = '0,
  parameter logic [ROW_W-1:0] EMR3    = '0
) (
  input logic            clk,
  input logic            reset,
  ddr_init_seq_if.master bus
);
  typedef enum logic [2:0] {IDLE, CKE_LOW, XPR_WAIT, CMD, WAIT, DONE} state_t;
  // Counters hold remaining cycles minus one, so a zero duration still lasts one cycle.
  localparam logic [CNT_W-1:0] W_CKE   = CNT_W'((T_CKE   > 1) ? T_CKE   - 1 : 0);
  localparam logic [CNT_W-1:0] W_XPR   = CNT_W'((T_XPR   > 1) ? T_XPR   - 1 : 0);
  localparam logic [CNT_W-1:0] W_RP    = CNT_W'((T_RP    > 1) ? T_RP    - 1 : 0);
  localparam logic [CNT_W-1:0] W_MRD   = CNT_W'((T_MRD   > 1) ? T_MRD   - 1 : 0);
  localparam logic [CNT_W-1:0] W_RFC   = CNT_W'((T_RFC   > 1) ? T_RFC   - 1 : 0);
  localparam logic [CNT_W-1:0] W_FINAL = CNT_W'((T_FINAL > 1) ? T_FINAL - 1 : 0);
  localparam logic [3:0]       LAST    = (DDR3 != 0) ? 4'd5 : 4'd11;
  localparam logic [ROW_W-1:0] A10     = ROW_W'(1024);
  localparam logic [ROW_W-1:0] DLL     = ROW_W'(256);
  localparam logic [ROW_W-1:0] OCD     = ROW_W'(896);
  localparam logic [3:0] P_DES = 4'b1111;
  localparam logic [3:0] P_NOP = 4'b0111;
  localparam logic [3:0] P_PRE = 4'b0010;
  localparam logic [3:0] P_REF = 4'b0001;
  localparam logic [3:0] P_MRS = 4'b0000;
  localparam logic [3:0] P_ZQ  = 4'b0110;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       step_q, step_d;
  logic [3:0]       pins_q, pins_d;
  logic [BA_W-1:0]  ba_q, ba_d;
  logic [ROW_W-1:0] a_q, a_d;
  logic             cke_q, cke_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             init_q;
  logic             start;
  logic [3:0]       nxt_step;
  logic [3:0]       c_pins;
  logic [BA_W-1:0]  c_ba;
  logic [ROW_W-1:0] c_a;
  logic [CNT_W-1:0] c_wait;
  assign start    = bus.initddr & ~init_q;
  assign nxt_step = step_q + 4'd1;
  // Command table: the command issued at nxt_step and the spacing to the one after it.
  always_comb begin
    c_pins = P_MRS;
    c_ba   = '0;
    c_a    = '0;
    c_wait = W_MRD;
    if (DDR3 != 0) begin
      case (nxt_step)
        4'd1:    begin c_ba = BA_W'(2); c_a = EMR2; end
        4'd2:    begin c_ba = BA_W'(3); c_a = EMR3; end
        4'd3:    begin c_ba = BA_W'(1); c_a = EMR1; end
        4'd4:    c_a = MR0 | DLL;
        4'd5:    begin c_pins = P_ZQ; c_a = A10; c_wait = W_FINAL; end
        default: ;
      endcase
    end else begin
      case (nxt_step)
        4'd1:    begin c_pins = P_PRE; c_a = A10; c_wait = W_RP; end
        4'd2:    begin c_ba = BA_W'(2); c_a = EMR2; end
        4'd3:    begin c_ba = BA_W'(3); c_a = EMR3; end
        4'd4:    begin c_ba = BA_W'(1); c_a = EMR1; end
        4'd5:    c_a = MR0 | DLL;
        4'd6:    begin c_pins = P_PRE; c_a = A10; c_wait = W_RP; end
        4'd7:    begin c_pins = P_REF; c_wait = W_RFC; end
        4'd8:    begin c_pins = P_REF; c_wait = W_RFC; end
        4'd9:    c_a = MR0 & ~DLL;
        4'd10:   begin c_ba = BA_W'(1); c_a = EMR1 | OCD; end
        4'd11:   begin c_ba = BA_W'(1); c_a = EMR1 & ~OCD; c_wait = W_FINAL; end
        default: ;
      endcase
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = CKE_LOW;
        cnt_d   = W_CKE;
        step_d  = 4'd0;
      end
      CKE_LOW: if (cnt_q == '0) begin
        state_d = XPR_WAIT;
        cnt_d   = W_XPR;
      end else cnt_d = cnt_q - 1'b1;
      XPR_WAIT: if (cnt_q == '0) begin
        state_d = CMD;
        cnt_d   = c_wait;
        step_d  = nxt_step;
      end else cnt_d = cnt_q - 1'b1;
      CMD, WAIT: if (cnt_q != '0) begin
        state_d = WAIT;
        cnt_d   = cnt_q - 1'b1;
      end else if (step_q == LAST) state_d = DONE;
      else begin
        state_d = CMD;
        cnt_d   = c_wait;
        step_d  = nxt_step;
      end
      default: state_d = IDLE;
    endcase
  end
  // Pins are computed from the next state so the registered outputs line up with the state.
  always_comb begin
    pins_d  = (state_d == IDLE) ? P_DES : (state_d == CMD) ? c_pins : P_NOP;
    ba_d    = (state_d == CMD) ? c_ba : '0;
    a_d     = (state_d == CMD) ? c_a : '0;
    cke_d   = (state_d != IDLE) && (state_d != CKE_LOW);
    ready_d = state_d == DONE;
    busy_d  = (state_d != IDLE) && (state_d != DONE);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      pins_q  <= P_DES;
      ba_q    <= '0;
      a_q     <= '0;
      cke_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      pins_q  <= pins_d;
      ba_q    <= ba_d;
      a_q     <= a_d;
      cke_q   <= cke_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      init_q  <= bus.initddr;
    end
  end
  assign {bus.csbar, bus.rasbar, bus.casbar, bus.webar} = pins_q;
  assign bus.cke   = cke_q;
  assign bus.ba    = ba_q;
  assign bus.a     = a_q;
  assign bus.odt   = 1'b0;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.step  = step_q;
endmodule

// File: tb/tb_ddr_init_seq.sv
// tb_ddr_init_seq: DDR2 and DDR3 instances checked against a command-table scoreboard keyed by cycle.
module tb_ddr_init_seq;
  typedef struct {
    logic [3:0]  pins;
    logic [1:0]  ba;
    logic [12:0] a;
    int          gap;
  } vec_t;
  typedef struct {
    int          t;
    logic [3:0]  pins;
    logic [1:0]  ba;
    logic [12:0] a;
    logic [3:0]  step;
  } exp_t;
  localparam logic [26:0] RST_V = {1'b0, 4'hf, 22'b0};
  logic clk = 1'b0;
  logic rst2_n, rst3_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  vec_t v2[11];
  vec_t v3[5];
  exp_t q2[$];
  exp_t q3[$];
  logic r2p = 1'b0;
  logic r3p = 1'b0;
  int   b;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  ddr_init_seq_if #(.ROW_W(13), .BA_W(2)) b2 ();
  ddr_init_seq_if #(.ROW_W(13), .BA_W(2)) b3 ();
  ddr_init_seq #(
    .DDR3(0), .ROW_W(13), .BA_W(2), .CNT_W(16), .T_CKE(10), .T_XPR(10), .T_RP(4), .T_MRD(4),
    .T_RFC(20), .T_FINAL(30), .MR0(13'h0532), .EMR1(13'h0184), .EMR2(13'h0008), .EMR3(13'h0003)
  ) u2 (.clk(clk), .reset(rst2_n), .bus(b2));
  ddr_init_seq #(
    .DDR3(1), .ROW_W(13), .BA_W(2), .CNT_W(16), .T_CKE(10), .T_XPR(10), .T_RP(4), .T_MRD(4),
    .T_RFC(20), .T_FINAL(30), .MR0(13'h0a30), .EMR1(13'h0046), .EMR2(13'h0018), .EMR3(13'h0004)
  ) u3 (.clk(clk), .reset(rst3_n), .bus(b3));
  function automatic logic [26:0] st2();
    return {b2.cke, b2.csbar, b2.rasbar, b2.casbar, b2.webar, b2.ba, b2.a, b2.odt, b2.ready, b2.busy, b2.step};
  endfunction
  function automatic logic [26:0] st3();
    return {b3.cke, b3.csbar, b3.rasbar, b3.casbar, b3.webar, b3.ba, b3.a, b3.odt, b3.ready, b3.busy, b3.step};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask
  // Expected commands start T_CKE+T_XPR=20 cycles after busy rises; ready follows the last gap.
  task automatic push(input bit d3, input int bcyc);
    int   t = bcyc + 20;
    int   n = d3 ? 5 : 11;
    vec_t v;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (d3) v = v3[i];
      else v = v2[i];
      e = '{t, v.pins, v.ba, v.a, 4'(i + 1)};
      if (d3) q3.push_back(e);
      else q2.push_back(e);
      t += v.gap;
    end
    e = '{t, 4'b0111, 2'd0, 13'd0, 4'(n)};
    if (d3) q3.push_back(e);
    else q2.push_back(e);
  endtask
  task automatic observe(input bit d3, input logic [3:0] p, input logic [1:0] ba, input logic [12:0] a,
                         input logic [3:0] st, input logic rdy, input logic rp);
    exp_t e;
    bit   ev;
    ev = ((p != 4'b0111) && (p != 4'b1111)) || (rdy && !rp);
    if (!ev) return;
    if ((d3 ? q3.size() : q2.size()) == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event dut=%0d pins=%b ba=%0d a=%0h ready=%b cyc=%0d", d3, p, ba, a, rdy, cyc);
      return;
    end
    if (d3) e = q3.pop_front();
    else e = q2.pop_front();
    chk($sformatf("d%0d_s%0d_cycle", d3, e.step), cyc, e.t);
    chk($sformatf("d%0d_s%0d_pins", d3, e.step), {28'd0, p}, {28'd0, e.pins});
    chk($sformatf("d%0d_s%0d_ba", d3, e.step), {30'd0, ba}, {30'd0, e.ba});
    chk($sformatf("d%0d_s%0d_a", d3, e.step), {19'd0, a}, {19'd0, e.a});
    chk($sformatf("d%0d_s%0d_step", d3, e.step), {28'd0, st}, {28'd0, e.step});
  endtask
  always @(negedge clk) begin
    observe(1'b0, {b2.csbar, b2.rasbar, b2.casbar, b2.webar}, b2.ba, b2.a, b2.step, b2.ready, r2p);
    r2p = b2.ready;
    observe(1'b1, {b3.csbar, b3.rasbar, b3.casbar, b3.webar}, b3.ba, b3.a, b3.step, b3.ready, r3p);
    r3p = b3.ready;
  end
  task automatic wait_drain(input bit d3, input int budget);
    int n = 0;
    while ((d3 ? q3.size() : q2.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("d%0d_drain_left", d3), d3 ? q3.size() : q2.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    v2[0]  = '{4'b0010, 2'd0, 13'h0400, 4};
    v2[1]  = '{4'b0000, 2'd2, 13'h0008, 4};
    v2[2]  = '{4'b0000, 2'd3, 13'h0003, 4};
    v2[3]  = '{4'b0000, 2'd1, 13'h0184, 4};
    v2[4]  = '{4'b0000, 2'd0, 13'h0532, 4};
    v2[5]  = '{4'b0010, 2'd0, 13'h0400, 4};
    v2[6]  = '{4'b0001, 2'd0, 13'h0000, 20};
    v2[7]  = '{4'b0001, 2'd0, 13'h0000, 20};
    v2[8]  = '{4'b0000, 2'd0, 13'h0432, 4};
    v2[9]  = '{4'b0000, 2'd1, 13'h0384, 4};
    v2[10] = '{4'b0000, 2'd1, 13'h0004, 30};
    v3[0]  = '{4'b0000, 2'd2, 13'h0018, 4};
    v3[1]  = '{4'b0000, 2'd3, 13'h0004, 4};
    v3[2]  = '{4'b0000, 2'd1, 13'h0046, 4};
    v3[3]  = '{4'b0000, 2'd0, 13'h0b30, 4};
    v3[4]  = '{4'b0110, 2'd0, 13'h0400, 30};
    rst2_n = 1'b0;
    rst3_n = 1'b0;
    b2.initddr = 1'b0;
    b3.initddr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      b2.initddr = ~b2.initddr;
      b3.initddr = ~b3.initddr;
      chk("rst_hold_d2", st2(), RST_V);
      chk("rst_hold_d3", st3(), RST_V);
    end
    @(negedge clk);
    rst2_n = 1'b1;
    rst3_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_d2", st2(), RST_V);
    chk("idle_d3", st3(), RST_V);
    b2.initddr = 1'b1;
    b = cyc + 1;
    push(1'b0, b);
    @(negedge clk);
    chk("d2_busy_rise", {b2.busy, b2.ready, b2.cke}, 3'b100);
    repeat (9) @(negedge clk);
    chk("d2_cke_low_end", b2.cke, 1'b0);
    @(negedge clk);
    chk("d2_cke_rise", b2.cke, 1'b1);
    while (cyc < b + 50) @(negedge clk);
    b2.initddr = 1'b0;
    @(negedge clk);
    b2.initddr = 1'b1;
    wait_drain(1'b0, 200);
    @(negedge clk);
    chk("d2_done", {b2.ready, b2.busy, b2.cke, b2.step}, {3'b101, 4'd11});
    chk("d2_done_nop", {b2.csbar, b2.rasbar, b2.casbar, b2.webar, b2.odt}, 5'b01110);
    b2.initddr = 1'b0;
    @(negedge clk);
    b2.initddr = 1'b1;
    b = cyc + 1;
    push(1'b0, b);
    @(negedge clk);
    chk("d2_restart", {b2.ready, b2.busy, b2.cke, b2.step}, {3'b010, 4'd0});
    wait_drain(1'b0, 200);
    b2.initddr = 1'b0;
    @(negedge clk);
    b2.initddr = 1'b1;
    b = cyc + 1;
    push(1'b0, b);
    while (cyc < b + 70) @(negedge clk);
    chk("d2_pre_reset_step", b2.step, 4'd8);
    @(posedge clk);
    #2;
    rst2_n = 1'b0;
    b2.initddr = 1'b0;
    #1;
    chk("d2_async_reset", st2(), RST_V);
    q2.delete();
    repeat (3) @(negedge clk);
    chk("d2_reset_hold", st2(), RST_V);
    rst2_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("d2_idle_after_reset", st2(), RST_V);
    b2.initddr = 1'b1;
    b = cyc + 1;
    push(1'b0, b);
    wait_drain(1'b0, 200);
    b3.initddr = 1'b1;
    b = cyc + 1;
    push(1'b1, b);
    @(negedge clk);
    chk("d3_busy_rise", {b3.busy, b3.ready, b3.cke}, 3'b100);
    wait_drain(1'b1, 150);
    @(negedge clk);
    chk("d3_done", {b3.ready, b3.busy, b3.cke, b3.step}, {3'b101, 4'd5});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
